// File: rtl/pipe_hazard_regs.sv
// pipe_hazard_regs -- consumer side of the hazard unit's stall/flush interface.
// Owns the PC register, the IF/ID register and the ID/EX register of a 5-stage
// MIPS pipeline and applies the stall/flush controls with fixed priorities.
//
// Ports:
//   clk, rst_n                          clock (rising edge), async active-low reset
//   stall_F, stall_D, flush_D, flush_E  hazard controls
//   pc_next_f, instr_f, pc_plus4_f      fetch-stage inputs
//   pc_f                                current PC
//   instr_d, pc_plus4_d, valid_d        IF/ID contents
//   ctrl_d, rd1_d, rd2_d, imm_d,
//   rs_d, rt_d, rd_d                    decode-stage inputs to ID/EX
//   ctrl_e, rd1_e, rd2_e, imm_e,
//   rs_e, rt_e, rd_e, valid_e           ID/EX contents
//   cnt_clr, stall_cnt, flush_cnt       performance counters (clear, values)
//   proto_err                           sticky illegal stall/flush combination
//
// Build option: define HAZ_PERF_CNT_EN to implement the stall/flush counters;
// without it both counters read 0 and cnt_clr is ignored.
module pipe_hazard_regs #(
  parameter int unsigned          DATA_W   = 32,
  parameter int unsigned          REG_W    = 5,
  parameter int unsigned          CTRL_W   = 10,
  parameter int unsigned          CNT_W    = 16,
  parameter logic [DATA_W-1:0]    RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_F,
  input  logic              stall_D,
  input  logic              flush_D,
  input  logic              flush_E,
  input  logic [DATA_W-1:0] pc_next_f,
  input  logic [DATA_W-1:0] instr_f,
  input  logic [DATA_W-1:0] pc_plus4_f,
  output logic [DATA_W-1:0] pc_f,
  output logic [DATA_W-1:0] instr_d,
  output logic [DATA_W-1:0] pc_plus4_d,
  output logic              valid_d,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic [DATA_W-1:0] rd1_d,
  input  logic [DATA_W-1:0] rd2_d,
  input  logic [DATA_W-1:0] imm_d,
  input  logic [REG_W-1:0]  rs_d,
  input  logic [REG_W-1:0]  rt_d,
  input  logic [REG_W-1:0]  rd_d,
  output logic [CTRL_W-1:0] ctrl_e,
  output logic [DATA_W-1:0] rd1_e,
  output logic [DATA_W-1:0] rd2_e,
  output logic [DATA_W-1:0] imm_e,
  output logic [REG_W-1:0]  rs_e,
  output logic [REG_W-1:0]  rt_e,
  output logic [REG_W-1:0]  rd_e,
  output logic              valid_e,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic              proto_err
);

  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_dn, pc4_q, pc4_d;
  logic              vd_q, vd_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_dn;
  logic [DATA_W-1:0] rd1_q, rd1_dn, rd2_q, rd2_dn, imm_q, imm_dn;
  logic [REG_W-1:0]  rs_q, rs_dn, rt_q, rt_dn, rdx_q, rdx_dn;
  logic              ve_q, ve_d;
  logic              err_q, err_d;

  always_comb begin
    pc_d = stall_F ? pc_q : pc_next_f;

    // stall_D outranks flush_D so a stalled decode instruction survives a redirect
    instr_dn = instr_q;
    pc4_d    = pc4_q;
    vd_d     = vd_q;
    if (!stall_D) begin
      if (flush_D) begin
        instr_dn = '0;
        pc4_d    = '0;
        vd_d     = 1'b0;
      end else begin
        instr_dn = instr_f;
        pc4_d    = pc_plus4_f;
        vd_d     = 1'b1;
      end
    end

    // ID/EX never holds: either a full bubble (rs/rt zeroed so forwarding
    // cannot match) or a fresh load from decode
    ctrl_dn = '0;
    rd1_dn  = '0;
    rd2_dn  = '0;
    imm_dn  = '0;
    rs_dn   = '0;
    rt_dn   = '0;
    rdx_dn  = '0;
    ve_d    = 1'b0;
    if (!flush_E) begin
      ctrl_dn = ctrl_d;
      rd1_dn  = rd1_d;
      rd2_dn  = rd2_d;
      imm_dn  = imm_d;
      rs_dn   = rs_d;
      rt_dn   = rt_d;
      rdx_dn  = rd_d;
      ve_d    = vd_q;
    end

    err_d = err_q | (stall_D & ~flush_E) | (stall_F ^ stall_D);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pc4_q   <= '0;
      vd_q    <= 1'b0;
      ctrl_q  <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rdx_q   <= '0;
      ve_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_dn;
      pc4_q   <= pc4_d;
      vd_q    <= vd_d;
      ctrl_q  <= ctrl_dn;
      rd1_q   <= rd1_dn;
      rd2_q   <= rd2_dn;
      imm_q   <= imm_dn;
      rs_q    <= rs_dn;
      rt_q    <= rt_dn;
      rdx_q   <= rdx_dn;
      ve_q    <= ve_d;
      err_q   <= err_d;
    end
  end

  assign pc_f       = pc_q;
  assign instr_d    = instr_q;
  assign pc_plus4_d = pc4_q;
  assign valid_d    = vd_q;
  assign ctrl_e     = ctrl_q;
  assign rd1_e      = rd1_q;
  assign rd2_e      = rd2_q;
  assign imm_e      = imm_q;
  assign rs_e       = rs_q;
  assign rt_e       = rt_q;
  assign rd_e       = rdx_q;
  assign valid_e    = ve_q;
  assign proto_err  = err_q;

`ifdef HAZ_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  // Saturating counters; a clear wins over a same-cycle increment
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_D && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_ONE;
      if (flush_E && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign stall_cnt      = '0;
  assign flush_cnt      = '0;
`endif

endmodule
